// File: rtl/serial_mod_pkg.sv
// Shared types and limits for the serial modulo checker family.
// Holds the frame FSM state type, mode selectors and parameter limits.
package serial_mod_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MODE_VALUE  = 0;
  localparam int MODE_POPCNT = 0 + 1;

  localparam int LANES_MAX = 8;
  localparam int MOD_MAX   = 256;

endpackage

// File: rtl/serial_mod_checker_if.sv
// Digit stream in / divisibility result out bundle for serial_mod_checker.
// The checker sits on the slave modport; the source drives through master.
interface serial_mod_checker_if #(
  parameter int LANES = 2,
  parameter int MOD   = 4
);
  localparam int RW = $clog2(MOD);

  logic             din_valid;
  logic             din_sof;
  logic             din_eof;
  logic [LANES-1:0] din;

  logic             out_valid;
  logic             div_o;
  logic             last_o;
  logic [RW-1:0]    residue_o;
  logic             err_o;

  modport master (
    output din_valid, din_sof, din_eof, din,
    input  out_valid, div_o, last_o, residue_o, err_o
  );

  modport slave (
    input  din_valid, din_sof, din_eof, din,
    output out_valid, div_o, last_o, residue_o, err_o
  );

endinterface

// File: rtl/serial_mod_checker_mod_step.sv
// mod_step: one combinational residue update, r_next from (base, din).
// Value mode shifts the digit in MSB-first; popcount mode adds its ones.
module mod_step
  import serial_mod_pkg::*;
#(
  parameter int LANES = 2,
  parameter int MOD   = 4,
  parameter int MODE  = MODE_VALUE,
  localparam int RW   = $clog2(MOD)
) (
  input  logic [RW-1:0]    base,
  input  logic [LANES-1:0] din,
  output logic [RW-1:0]    r_next
);

  generate
    if (MODE == MODE_VALUE) begin : g_value
      localparam logic [RW+LANES-1:0] MOD_W = (RW + LANES)'(MOD);

      logic [RW+LANES-1:0] wide;
      logic [RW+LANES-1:0] wide_mod;

      // base * 2^LANES + din is just the concatenation; it cannot overflow.
      assign wide     = {base, din};
      assign wide_mod = wide % MOD_W;
      assign r_next   = RW'(wide_mod);
    end else begin : g_popcnt
      localparam logic [8:0]  MOD_P = 9'(MOD);
      localparam logic [RW:0] MOD_S = (RW + 1)'(MOD);

      logic [3:0]  cnt [0:LANES];
      logic [8:0]  pc_wide;
      logic [8:0]  pc_mod;
      logic [RW:0] sum;

      assign cnt[0] = 4'd0;
      for (genvar gi = 0; gi < LANES; gi++) begin : g_cnt
        assign cnt[gi+1] = cnt[gi] + {3'b000, din[gi]};
      end

      // Reduce the count first so base + count stays below 2*MOD for small MOD.
      assign pc_wide = {5'b00000, cnt[LANES]};
      assign pc_mod  = pc_wide % MOD_P;
      assign sum     = {1'b0, base} + (RW + 1)'(pc_mod);
      assign r_next  = (sum >= MOD_S) ? RW'(sum - MOD_S) : RW'(sum);
    end
  endgenerate

endmodule

// File: rtl/serial_mod_checker.sv
// Streaming divisibility checker: running residue mod MOD over framed digits.
// Define SERIAL_MOD_CHECKER_REG_OUT_EN to register all outputs (latency 1).
module serial_mod_checker
  import serial_mod_pkg::*;
#(
  parameter int LANES = 2,
  parameter int MOD   = 4,
  parameter int MODE  = MODE_VALUE
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_mod_checker_if.slave  bus
);

  localparam int RW = $clog2(MOD);

  generate
    if (LANES < 1 || LANES > LANES_MAX) begin : g_bad_lanes
      $fatal(1, "serial_mod_checker: LANES out of range 1..8");
    end
    if (MOD < 2 || MOD > MOD_MAX) begin : g_bad_mod
      $fatal(1, "serial_mod_checker: MOD out of range 2..256");
    end
    if (MODE != MODE_VALUE && MODE != MODE_POPCNT) begin : g_bad_mode
      $fatal(1, "serial_mod_checker: MODE must be 0 or 1");
    end
  endgenerate

  state_t        state_reg;
  state_t        state_next;
  logic [RW-1:0] residue_reg;
  logic [RW-1:0] residue_next;
  logic [RW-1:0] base;
  logic [RW-1:0] r_next;
  logic          accept;
  logic          drop;

  logic          out_valid_c;
  logic          div_c;
  logic          last_c;
  logic [RW-1:0] residue_c;
  logic          err_c;

  // A sof always starts from zero, even when it aborts a frame in progress.
  assign base = bus.din_sof ? '0 : residue_reg;

  mod_step #(
    .LANES (LANES),
    .MOD   (MOD),
    .MODE  (MODE)
  ) u_step (
    .base   (base),
    .din    (bus.din),
    .r_next (r_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      residue_reg <= '0;
    end else begin
      state_reg   <= state_next;
      residue_reg <= residue_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    residue_next = residue_reg;
    accept       = bus.din_valid & (bus.din_sof | (state_reg == ACTIVE));
    drop         = bus.din_valid & ~accept;
    if (accept) begin
      residue_next = r_next;
      state_next   = bus.din_eof ? IDLE : ACTIVE;
    end
  end

  always_comb begin
    out_valid_c = accept;
    div_c       = accept & (r_next == '0);
    last_c      = accept & bus.din_eof;
    residue_c   = accept ? r_next : residue_reg;
    err_c       = drop;
  end

`ifdef SERIAL_MOD_CHECKER_REG_OUT_EN
  logic          out_valid_reg;
  logic          div_reg;
  logic          last_reg;
  logic [RW-1:0] residue_out_reg;
  logic          err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      div_reg         <= 1'b0;
      last_reg        <= 1'b0;
      residue_out_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      out_valid_reg   <= out_valid_c;
      div_reg         <= div_c;
      last_reg        <= last_c;
      residue_out_reg <= residue_c;
      err_reg         <= err_c;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.div_o     = div_reg;
  assign bus.last_o    = last_reg;
  assign bus.residue_o = residue_out_reg;
  assign bus.err_o     = err_reg;
`else
  // Mealy path: hold outputs at their reset values while rst is asserted.
  assign bus.out_valid = out_valid_c & ~rst;
  assign bus.div_o     = div_c & ~rst;
  assign bus.last_o    = last_c & ~rst;
  assign bus.residue_o = rst ? '0 : residue_c;
  assign bus.err_o     = err_c & ~rst;
`endif

endmodule
